// File: rtl/seq_mul_su_pkg.sv
// Shared definitions for the iterative signed x unsigned multiplier seq_mul_su.
// FSM state encodings and digit-count helpers derived from the unsigned operand width.
package seq_mul_su_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Number of radix-4 digits in an unsigned operand of width w_u.
  function automatic int digits(input int w_u);
    return w_u / 2;
  endfunction

  // Digit counter width; kept at least one bit so a single-digit build still has a counter.
  function automatic int cnt_w(input int w_u);
    return (w_u / 2 > 1) ? $clog2(w_u / 2) : 1;
  endfunction

endpackage

// File: rtl/seq_mul_su_digit.sv
// Combinational signed W_S x unsigned 2-bit digit multiply, result W_S+2 bits signed.
// Formed as the sum of 2*s and s, each gated by one digit bit.
module mul_digit_su #(
  parameter int W_S = 4
) (
  input  logic signed [W_S-1:0] s,
  input  logic        [1:0]     d,
  output logic signed [W_S+1:0] p
);

  logic signed [W_S+1:0] s_x1;
  logic signed [W_S+1:0] s_x2;

  always_comb begin
    s_x1 = {{2{s[W_S-1]}}, s};
    s_x2 = {s[W_S-1], s, 1'b0};
    p    = (d[0] ? s_x1 : '0) + (d[1] ? s_x2 : '0);
  end

endmodule

// File: rtl/seq_mul_su.sv
// Iterative signed (s) x unsigned (u) multiplier, one radix-4 digit of u per cycle.
// Optional macro SEQ_MUL_SU_EARLY_TERM_EN stops once the remaining digits of u are all zero.
module seq_mul_su
  import seq_mul_su_pkg::*;
#(
  parameter int W_S = 4,
  parameter int W_U = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W_S-1:0]         s,
  input  logic [W_U-1:0]         u,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W_S+W_U-1:0]     product,
  output logic                   busy
);

  localparam int P   = W_S + W_U;
  localparam int DIG = digits(W_U);
  localparam int CW  = cnt_w(W_U);

  state_t                state_q, state_d;
  logic signed [W_S-1:0] s_q, s_d;
  logic [W_U-1:0]        u_q, u_d;
  logic signed [P-1:0]   acc_q, acc_d;
  logic [P-1:0]          product_q, product_d;
  logic [CW-1:0]         k_q, k_d;

  logic signed [W_S+1:0] pp;
  logic signed [P-1:0]   pp_ext;
  logic signed [P-1:0]   addend;
  logic signed [P-1:0]   acc_sum;
  logic                  last_digit;
  logic                  accept;

  mul_digit_su #(.W_S(W_S)) u_digit (
    .s (s_q),
    .d (u_q[1:0]),
    .p (pp)
  );

  // u_q shifts right each BUSY cycle, so the current digit is always in its low two bits.
  always_comb begin
    pp_ext  = P'(pp);
    addend  = pp_ext << {k_q, 1'b0};
    acc_sum = acc_q + addend;
`ifdef SEQ_MUL_SU_EARLY_TERM_EN
    last_digit = (k_q == CW'(DIG - 1)) || ((u_q >> 2) == '0);
`else
    last_digit = (k_q == CW'(DIG - 1));
`endif
  end

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid/product stay stable until out_ready, and in_ready only rises in IDLE or as DONE drains.
  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    accept    = in_valid && in_ready;
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_BUSY);
    product   = product_q;
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    u_d       = u_q;
    acc_d     = acc_q;
    product_d = product_q;
    k_d       = k_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_BUSY: begin
        acc_d = acc_sum;
        u_d   = u_q >> 2;
        k_d   = k_q + CW'(1);
        if (last_digit) begin
          state_d   = ST_DONE;
          product_d = acc_sum;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A new capture from IDLE or straight out of DONE overrides the above.
    if (accept) begin
      state_d = ST_BUSY;
      s_d     = s;
      u_d     = u;
      acc_d   = '0;
      k_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      u_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      k_q       <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      u_q       <= u_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      k_q       <= k_d;
    end
  end

endmodule
